axi_port_arbiter: RTL and testbench

//  Shares one single-beat AXI4 master port among NUM_REQ requesting memory sub-units (e.g. fetch, load/store).

---
 rtl/axi_port_arbiter_if.sv | 78 +++++++
 rtl/axi_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_port_arbiter_if.sv
// Bundle of requester-side and AXI master-side channels seen by axi_port_arbiter.
// The master modport is the arbiter's view; slave is the view of requesters plus the external bus.
interface axi_port_arbiter_if #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   // Requester side
   logic [NUM_REQ-1:0]        s_arvalid;
   logic [NUM_REQ-1:0]        s_arlock;
   logic [NUM_REQ*ADDR_W-1:0] s_araddr;
   logic [NUM_REQ-1:0]        s_arready;
   logic [NUM_REQ-1:0]        s_rvalid;
   logic [DATA_W-1:0]         s_rdata;
   logic [1:0]                s_rresp;
   logic [NUM_REQ-1:0]        s_awvalid;
   logic [NUM_REQ-1:0]        s_awlock;
   logic [NUM_REQ*ADDR_W-1:0] s_awaddr;
   logic [NUM_REQ-1:0]        s_awready;
   logic [NUM_REQ-1:0]        s_wvalid;
   logic [NUM_REQ*DATA_W-1:0] s_wdata;
   logic [NUM_REQ*STRB_W-1:0] s_wstrb;
   logic [NUM_REQ-1:0]        s_wready;
   logic [NUM_REQ-1:0]        s_bvalid;
   logic [1:0]                s_bresp;

   // External AXI4 master port
   logic              m_arvalid;
   logic              m_arready;
   logic [ADDR_W-1:0] m_araddr;
   logic              m_arlock;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic [3:0]        m_arid;
   logic              m_rvalid;
   logic              m_rready;
   logic [DATA_W-1:0] m_rdata;
   logic [1:0]        m_rresp;
   logic              m_awvalid;
   logic              m_awready;
   logic [ADDR_W-1:0] m_awaddr;
   logic              m_awlock;
   logic [7:0]        m_awlen;
   logic [2:0]        m_awsize;
   logic [1:0]        m_awburst;
   logic [3:0]        m_awid;
   logic              m_wvalid;
   logic              m_wready;
   logic [DATA_W-1:0] m_wdata;
   logic [STRB_W-1:0] m_wstrb;
   logic              m_wlast;
   logic              m_bvalid;
   logic              m_bready;
   logic [1:0]        m_bresp;

   modport master (
      input  s_arvalid, s_arlock, s_araddr, s_awvalid, s_awlock, s_awaddr,
      input  s_wvalid, s_wdata, s_wstrb,
      output s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
      output m_arvalid, m_araddr, m_arlock, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
      output m_awvalid, m_awaddr, m_awlock, m_awlen, m_awsize, m_awburst, m_awid,
      output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
      input  m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid, m_bresp
   );

   modport slave (
      output s_arvalid, s_arlock, s_araddr, s_awvalid, s_awlock, s_awaddr,
      output s_wvalid, s_wdata, s_wstrb,
      input  s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
      input  m_arvalid, m_araddr, m_arlock, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
      input  m_awvalid, m_awaddr, m_awlock, m_awlen, m_awsize, m_awburst, m_awid,
      input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
      output m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid, m_bresp
   );
endinterface

// File: rtl/axi_port_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 master port among NUM_REQ sub-units,
// one transaction in flight, with the grant held across exclusive (locked) sequences.
module axi_port_arbiter #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned LOCK_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   axi_port_arbiter_if.master         bus,
   output logic [$clog2(NUM_REQ)-1:0] grant,
   output logic                       busy
);
   localparam int unsigned GrantW = $clog2(NUM_REQ);
   localparam int unsigned StrbW  = DATA_W / 8;
   localparam int unsigned CntW   = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StArIssue, StRWait, StWIssue, StBWait} state_e;

   state_e            state_q, state_d;
   logic [GrantW-1:0] grant_q, grant_d;
   logic [GrantW-1:0] rr_ptr_q, rr_ptr_d;
   logic              lock_hold_q, lock_hold_d;
   logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              ar_lock_q, ar_lock_d;

   logic [NUM_REQ-1:0] req;
   logic               found;
   logic [GrantW-1:0]  winner;
   logic [GrantW-1:0]  rr_next;
   int unsigned        idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         lock_hold_q <= 1'b0;
         lock_cnt_q  <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         ar_lock_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_hold_q <= lock_hold_d;
         lock_cnt_q  <= lock_cnt_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         ar_lock_q   <= ar_lock_d;
      end
   end

   // Request/address/data muxing follows the registered grant.
   always_comb begin
      bus.m_araddr  = bus.s_araddr[int'(grant_q)*ADDR_W +: ADDR_W];
      bus.m_arlock  = bus.s_arlock[grant_q];
      bus.m_awaddr  = bus.s_awaddr[int'(grant_q)*ADDR_W +: ADDR_W];
      bus.m_awlock  = bus.s_awlock[grant_q];
      bus.m_wdata   = bus.s_wdata[int'(grant_q)*DATA_W +: DATA_W];
      bus.m_wstrb   = bus.s_wstrb[int'(grant_q)*StrbW +: StrbW];
      bus.m_arlen   = 8'd0;
      bus.m_arsize  = 3'($clog2(StrbW));
      bus.m_arburst = 2'b00;
      bus.m_arid    = 4'd0;
      bus.m_awlen   = 8'd0;
      bus.m_awsize  = 3'($clog2(StrbW));
      bus.m_awburst = 2'b00;
      bus.m_awid    = 4'd0;
      bus.m_wlast   = 1'b1;
      bus.m_rready  = 1'b1;
      bus.m_bready  = 1'b1;
      bus.s_rdata   = bus.m_rdata;
      bus.s_rresp   = bus.m_rresp;
      bus.s_bresp   = bus.m_bresp;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      lock_hold_d = lock_hold_q;
      lock_cnt_d  = lock_cnt_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      ar_lock_d   = ar_lock_q;
      req         = bus.s_arvalid | bus.s_awvalid;
      found       = 1'b0;
      winner      = '0;
      idx         = 0;
      rr_next     = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

      bus.m_arvalid = 1'b0;
      bus.m_awvalid = 1'b0;
      bus.m_wvalid  = 1'b0;
      bus.s_arready = '0;
      bus.s_rvalid  = '0;
      bus.s_awready = '0;
      bus.s_wready  = '0;
      bus.s_bvalid  = '0;

      unique case (state_q)
         StIdle: begin
            // While an exclusive sequence is held, grant_q still names the holder.
            if (lock_hold_q) begin
               if (req[grant_q]) begin
                  found  = 1'b1;
                  winner = grant_q;
               end
            end else begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                  if (!found && req[idx]) begin
                     found  = 1'b1;
                     winner = GrantW'(idx);
                  end
               end
            end
            if (found) begin
               grant_d    = winner;
               lock_cnt_d = '0;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               state_d    = bus.s_awvalid[winner] ? StWIssue : StArIssue;
            end else if (lock_hold_q) begin
               if (lock_cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                  lock_hold_d = 1'b0;
                  lock_cnt_d  = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
         end
         StArIssue: begin
            bus.m_arvalid          = 1'b1;
            bus.s_arready[grant_q] = bus.m_arready;
            if (bus.m_arready) begin
               ar_lock_d = bus.m_arlock;
               state_d   = StRWait;
            end
         end
         StRWait: begin
            bus.s_rvalid[grant_q] = bus.m_rvalid;
            if (bus.m_rvalid) begin
               state_d     = StIdle;
               rr_ptr_d    = rr_next;
               lock_hold_d = ar_lock_q;
               lock_cnt_d  = '0;
            end
         end
         StWIssue: begin
            bus.m_awvalid          = ~aw_done_q;
            bus.m_wvalid           = ~w_done_q;
            bus.s_awready[grant_q] = bus.m_awready & ~aw_done_q;
            bus.s_wready[grant_q]  = bus.m_wready & ~w_done_q;
            aw_done_d = aw_done_q | bus.m_awready;
            w_done_d  = w_done_q | bus.m_wready;
            if (aw_done_d && w_done_d) begin
               state_d = StBWait;
            end
         end
         StBWait: begin
            bus.s_bvalid[grant_q] = bus.m_bvalid;
            if (bus.m_bvalid) begin
               state_d     = StIdle;
               rr_ptr_d    = rr_next;
               lock_hold_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign grant = grant_q;
   assign busy  = (state_q != StIdle);
endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter: round-robin, write path, exclusive hold, lock timeout,
// write-before-read priority and asynchronous reset during a read.
module tb_axi_port_arbiter;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic grant;
   logic busy;
   int   checks   = 0;
   int   failures = 0;
   int   n;
   logic seen;

   always #5 clk = ~clk;

   axi_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

   axi_port_arbiter #(
      .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .LOCK_TIMEOUT(64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .grant (grant),
      .busy  (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.s_arvalid = '0; bus.s_arlock = '0; bus.s_araddr = '0;
      bus.s_awvalid = '0; bus.s_awlock = '0; bus.s_awaddr = '0;
      bus.s_wvalid  = '0; bus.s_wdata  = '0; bus.s_wstrb  = '0;
      bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rresp = 2'b00;
      bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_m_arvalid", bus.m_arvalid, 0);
      chk("rst_m_awvalid", bus.m_awvalid, 0);
      chk("rst_s_arready", bus.s_arready, 0);
      chk("rst_m_rready", bus.m_rready, 1);
      chk("rst_m_bready", bus.m_bready, 1);
      @(negedge clk) rst_n = 1'b1;
      cyc();

      // Two simultaneous reads: req0 then req1
      bus.s_araddr = {32'h0000_2000, 32'h0000_1000};
      bus.s_arvalid = 2'b11; bus.m_arready = 1'b1; #1;
      chk("rr_idle_busy", busy, 0);
      cyc(); #1;
      chk("rr_first_grant", grant, 0);
      chk("rr_first_arvalid", bus.m_arvalid, 1);
      chk("rr_first_araddr", bus.m_araddr, 32'h1000);
      chk("rr_first_s_arready", bus.s_arready, 2'b01);
      cyc(); bus.s_arvalid = 2'b10; #1;
      chk("rr_rwait_arvalid", bus.m_arvalid, 0);
      chk("rr_rwait_busy", busy, 1);
      cyc(); bus.m_rvalid = 1'b1; bus.m_rdata = 32'hAAAA_0001; #1;
      chk("rr_first_s_rvalid", bus.s_rvalid, 2'b01);
      chk("rr_first_rdata", bus.s_rdata, 32'hAAAA_0001);
      cyc(); bus.m_rvalid = 1'b0; #1;
      chk("rr_gap_busy", busy, 0);
      cyc(); #1;
      chk("rr_second_grant", grant, 1);
      chk("rr_second_araddr", bus.m_araddr, 32'h2000);
      chk("rr_second_s_arready", bus.s_arready, 2'b10);
      cyc(); bus.s_arvalid = 2'b00; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hAAAA_0002; #1;
      chk("rr_second_s_rvalid", bus.s_rvalid, 2'b10);
      cyc(); bus.m_rvalid = 1'b0; bus.m_arready = 1'b0; #1;
      chk("rr_done_busy", busy, 0);

      // Req1 write, W accepted one cycle before AW
      bus.s_awaddr = {32'h0000_0100, 32'h0};
      bus.s_wdata  = {32'hDEAD_BEEF, 32'h0};
      bus.s_wstrb  = {4'hF, 4'h0};
      bus.s_awvalid = 2'b10; bus.s_wvalid = 2'b10; #1;
      cyc(); bus.m_wready = 1'b1; #1;
      chk("wr_grant", grant, 1);
      chk("wr_awvalid", bus.m_awvalid, 1);
      chk("wr_wvalid", bus.m_wvalid, 1);
      chk("wr_awaddr", bus.m_awaddr, 32'h100);
      chk("wr_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      chk("wr_wstrb", bus.m_wstrb, 4'hF);
      chk("wr_s_wready", bus.s_wready, 2'b10);
      chk("wr_s_awready_early", bus.s_awready, 2'b00);
      cyc(); bus.s_wvalid = 2'b00; bus.m_awready = 1'b1; #1;
      chk("wr_wvalid_done", bus.m_wvalid, 0);
      chk("wr_awvalid_held", bus.m_awvalid, 1);
      chk("wr_s_awready", bus.s_awready, 2'b10);
      chk("wr_s_wready_done", bus.s_wready, 2'b00);
      cyc();
      bus.s_awvalid = 2'b00; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
      bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00; #1;
      chk("wr_bwait_awvalid", bus.m_awvalid, 0);
      chk("wr_s_bvalid", bus.s_bvalid, 2'b10);
      chk("wr_bwait_busy", busy, 1);
      cyc(); bus.m_bvalid = 1'b0; #1;
      chk("wr_done_busy", busy, 0);
      chk("wr_done_s_bvalid", bus.s_bvalid, 2'b00);

      // Exclusive pair by req0 blocks req1
      bus.s_araddr = {32'h0000_4000, 32'h0000_3000};
      bus.s_arvalid = 2'b01; bus.s_arlock = 2'b01; bus.m_arready = 1'b1; #1;
      cyc(); #1;
      chk("lk_grant", grant, 0);
      chk("lk_arlock", bus.m_arlock, 1);
      chk("lk_araddr", bus.m_araddr, 32'h3000);
      cyc();
      bus.s_arvalid = 2'b00; bus.s_arlock = 2'b00; bus.m_rvalid = 1'b1; bus.m_rresp = 2'b01; #1;
      chk("lk_s_rvalid", bus.s_rvalid, 2'b01);
      chk("lk_s_rresp", bus.s_rresp, 2'b01);
      cyc(); bus.m_rvalid = 1'b0; bus.m_rresp = 2'b00; bus.s_arvalid = 2'b10; #1;
      chk("lk_idle_busy", busy, 0);
      repeat (3) cyc();
      #1;
      chk("lk_blocked_busy", busy, 0);
      chk("lk_blocked_grant", grant, 0);
      bus.s_awaddr = {32'h0, 32'h0000_3000};
      bus.s_wdata  = {32'h0, 32'h1234_5678};
      bus.s_wstrb  = {4'h0, 4'hF};
      bus.s_awvalid = 2'b01; bus.s_awlock = 2'b01; bus.s_wvalid = 2'b01;
      bus.m_awready = 1'b1; bus.m_wready = 1'b1; #1;
      cyc(); #1;
      chk("lk_wr_grant", grant, 0);
      chk("lk_wr_awlock", bus.m_awlock, 1);
      chk("lk_wr_s_awready", bus.s_awready, 2'b01);
      chk("lk_wr_s_wready", bus.s_wready, 2'b01);
      chk("lk_wr_s_arready", bus.s_arready, 2'b00);
      cyc();
      bus.s_awvalid = 2'b00; bus.s_awlock = 2'b00; bus.s_wvalid = 2'b00;
      bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b1; bus.m_bresp = 2'b01; #1;
      chk("lk_s_bvalid", bus.s_bvalid, 2'b01);
      chk("lk_s_bresp", bus.s_bresp, 2'b01);
      cyc(); bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00; #1;
      chk("lk_release_busy", busy, 0);
      cyc(); #1;
      chk("lk_req1_grant", grant, 1);
      chk("lk_req1_arvalid", bus.m_arvalid, 1);
      chk("lk_req1_araddr", bus.m_araddr, 32'h4000);
      cyc(); bus.s_arvalid = 2'b00; bus.m_rvalid = 1'b1; #1;
      cyc(); bus.m_rvalid = 1'b0; #1;

      // Exclusive read with no follow-up: hold expires after 64 idle cycles
      bus.s_arvalid = 2'b01; bus.s_arlock = 2'b01; #1;
      cyc();
      cyc(); bus.s_arvalid = 2'b00; bus.s_arlock = 2'b00; bus.m_rvalid = 1'b1; #1;
      cyc(); bus.m_rvalid = 1'b0; bus.s_arvalid = 2'b10; #1;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         cyc();
         n++;
         if (busy) seen = 1'b1;
      end
      chk("to_grant_cycle", n, 65);
      chk("to_grant", grant, 1);
      cyc(); bus.s_arvalid = 2'b00; bus.m_rvalid = 1'b1; #1;
      cyc(); bus.m_rvalid = 1'b0; #1;
      chk("to_done_busy", busy, 0);

      // Same requester with AW and AR together: write first
      bus.s_araddr = {32'h0, 32'h0000_5000};
      bus.s_awaddr = {32'h0, 32'h0000_6000};
      bus.s_arvalid = 2'b01; bus.s_awvalid = 2'b01; bus.s_wvalid = 2'b01;
      bus.m_awready = 1'b1; bus.m_wready = 1'b1; #1;
      cyc(); #1;
      chk("wf_awvalid", bus.m_awvalid, 1);
      chk("wf_arvalid", bus.m_arvalid, 0);
      chk("wf_awaddr", bus.m_awaddr, 32'h6000);
      cyc(); bus.s_awvalid = 2'b00; bus.s_wvalid = 2'b00; bus.m_bvalid = 1'b1; #1;
      chk("wf_s_bvalid", bus.s_bvalid, 2'b01);
      cyc(); bus.m_bvalid = 1'b0; #1;
      chk("wf_gap_busy", busy, 0);
      cyc(); #1;
      chk("wf_rd_arvalid", bus.m_arvalid, 1);
      chk("wf_rd_grant", grant, 0);
      chk("wf_rd_araddr", bus.m_araddr, 32'h5000);
      cyc(); bus.s_arvalid = 2'b00; bus.m_rvalid = 1'b1; #1;
      cyc(); bus.m_rvalid = 1'b0; #1;

      // Asynchronous reset in the middle of R_WAIT
      bus.s_araddr = {32'h0000_7000, 32'h0};
      bus.s_arvalid = 2'b10; #1;
      cyc(); #1;
      chk("ar_pre_grant", grant, 1);
      cyc(); bus.s_arvalid = 2'b00; bus.m_rvalid = 1'b1; #1;
      chk("ar_pre_s_rvalid", bus.s_rvalid, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_rst_s_rvalid", bus.s_rvalid, 2'b00);
      chk("ar_rst_busy", busy, 0);
      chk("ar_rst_arvalid", bus.m_arvalid, 0);
      chk("ar_rst_grant", grant, 0);
      bus.m_rvalid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cyc(); #1;
      chk("ar_post_grant", grant, 0);
      chk("ar_post_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
